// File: rtl/sr_flag_arbiter_pkg.sv
// Shared types and constants for the sr_ff flag-bank arbiter.
package sr_flag_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_VERIFY = 2'd2
    } state_e;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

endpackage

// File: rtl/sr_flag_arbiter_if.sv
// Requester-side command bundle: per-requester valid/op/idx with a one-hot ready back.
interface sr_flag_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 3
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_op;
    logic [NUM_REQ*IDX_W-1:0] req_idx;
    logic [NUM_REQ-1:0]       req_ready;

    modport master (output req_valid, output req_op, output req_idx, input  req_ready);
    modport slave  (input  req_valid, input  req_op, input  req_idx, output req_ready);
endinterface

// File: rtl/sr_flag_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module sr_flag_arbiter_rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);

    logic            found;
    logic [ID_W-1:0] k;
    int              sum;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        k      = '0;
        sum    = 0;
        for (int off = 0; off < N; off++) begin
            sum = int'(ptr) + off;
            if (sum >= N) sum = sum - N;
            k = ID_W'(sum);
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                gnt_id = k;
            end
        end
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Arbitrates SET/RESET commands onto a shared sr_ff bank with a drive/verify sequence.
// state     | meaning
// ST_IDLE   | arbitrating; accepted command loads a one-cycle s/r pulse
// ST_DRIVE  | pulse on s_out/r_out; cleared at the next edge when the sr_ff samples it
// ST_VERIFY | compare flag_q against the op; done/err update at the closing edge
module sr_flag_arbiter
    import sr_flag_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_FLAGS = 8,
    parameter int IDX_W     = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    sr_flag_arbiter_if.slave           req_if,
    output logic [NUM_FLAGS-1:0]       s_out,
    output logic [NUM_FLAGS-1:0]       r_out,
    input  logic [NUM_FLAGS-1:0]       flag_q,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_gid,
    output logic                       err,
    input  logic                       err_clr,
    output logic [IDX_W-1:0]           err_idx
);

    localparam int GID_W = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [GID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GID_W-1:0]     gid_q, gid_d;
    logic [GID_W-1:0]     done_gid_q, done_gid_d;
    logic                 op_q, op_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     err_idx_q, err_idx_d;
    logic [NUM_FLAGS-1:0] s_q, s_d, r_q, r_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [NUM_REQ-1:0]   gnt;
    logic [GID_W-1:0]     gnt_id;
    logic                 accept;
    logic                 acc_op;
    logic [IDX_W-1:0]     acc_idx;
    logic                 acc_in_range;
    logic                 cmd_in_range;
    logic                 verify_fail;

    sr_flag_arbiter_rr_arbiter #(.N(NUM_REQ), .ID_W(GID_W)) u_arb (
        .req    (req_if.req_valid),
        .ptr    (rr_ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_if.req_ready = (rst_n && state_q == ST_IDLE) ? gnt : '0;
    assign accept           = |(req_if.req_valid & req_if.req_ready);
    assign acc_op           = req_if.req_op[gnt_id];
    assign acc_idx          = req_if.req_idx[int'(gnt_id)*IDX_W +: IDX_W];
    assign acc_in_range     = int'(acc_idx) < NUM_FLAGS;
    assign cmd_in_range     = int'(idx_q) < NUM_FLAGS;
    // Out-of-range commands drove nothing, so they always count as a verify failure.
    assign verify_fail      = !cmd_in_range || (flag_q[idx_q] != op_q);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gid_d      = gid_q;
        op_d       = op_q;
        idx_d      = idx_q;
        s_d        = '0;
        r_d        = '0;
        done_d     = 1'b0;
        done_gid_d = done_gid_q;
        err_d      = err_q;
        err_idx_d  = err_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_DRIVE;
                    gid_d   = gnt_id;
                    op_d    = acc_op;
                    idx_d   = acc_idx;
                    if (int'(gnt_id) == NUM_REQ - 1) rr_ptr_d = '0;
                    else                             rr_ptr_d = gnt_id + GID_W'(1);
                    if (acc_in_range) begin
                        s_d[acc_idx] = (acc_op == OP_SET);
                        r_d[acc_idx] = (acc_op == OP_RESET);
                    end
                end
            end
            ST_DRIVE: state_d = ST_VERIFY;
            ST_VERIFY: begin
                state_d    = ST_IDLE;
                done_d     = 1'b1;
                done_gid_d = gid_q;
                if (verify_fail) begin
                    err_d = 1'b1;
                    if (!err_q) err_idx_d = idx_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Clearing wins over an error reported in the same cycle.
        if (err_clr) begin
            err_d     = 1'b0;
            err_idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            gid_q      <= '0;
            op_q       <= 1'b0;
            idx_q      <= '0;
            s_q        <= '0;
            r_q        <= '0;
            done_q     <= 1'b0;
            done_gid_q <= '0;
            err_q      <= 1'b0;
            err_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gid_q      <= gid_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            s_q        <= s_d;
            r_q        <= r_d;
            done_q     <= done_d;
            done_gid_q <= done_gid_d;
            err_q      <= err_d;
            err_idx_q  <= err_idx_d;
        end
    end

    assign s_out    = s_q;
    assign r_out    = r_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign done_gid = done_gid_q;
    assign err      = err_q;
    assign err_idx  = err_idx_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed and randomized checks of sr_flag_arbiter against a behavioural sr_ff bank.
module tb_sr_flag_arbiter;

    localparam int NR = 4;
    localparam int NF = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NF-1:0] s_out, r_out, flag_q;
    logic [NF-1:0] bank_q = '0;
    logic [NF-1:0] force_mask = '0;
    logic [NF-1:0] force_val = '0;
    logic          busy, done, err;
    logic          err_clr = 1'b0;
    logic [1:0]    done_gid;
    logic [IW-1:0] err_idx;
    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    sr_flag_arbiter_if #(.NUM_REQ(NR), .IDX_W(IW)) req_if ();

    sr_flag_arbiter #(.NUM_REQ(NR), .NUM_FLAGS(NF), .IDX_W(IW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_if   (req_if),
        .s_out    (s_out),
        .r_out    (r_out),
        .flag_q   (flag_q),
        .busy     (busy),
        .done     (done),
        .done_gid (done_gid),
        .err      (err),
        .err_clr  (err_clr),
        .err_idx  (err_idx)
    );

    // Behavioural sr_ff bank; the force mask lets a test corrupt the feedback.
    always @(posedge clk) begin
        for (int i = 0; i < NF; i++) begin
            if (s_out[i] && !r_out[i])      bank_q[i] <= 1'b1;
            else if (r_out[i] && !s_out[i]) bank_q[i] <= 1'b0;
        end
    end
    assign flag_q = (bank_q & ~force_mask) | (force_val & force_mask);

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(input int k, input logic v, input logic op, input logic [IW-1:0] idx);
        req_if.req_valid[k]        = v;
        req_if.req_op[k]           = op;
        req_if.req_idx[k*IW +: IW] = idx;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_if.req_valid = '1;
        cyc(2);
        tests++;
        if (req_if.req_ready !== 4'b0000) begin
            fails++; $display("FAIL reset_ready got=%b exp=0000", req_if.req_ready);
        end
        req_if.req_valid = '0;
        rst_n = 1'b1;
        cyc(1);
        tests++;
        if ({s_out, r_out, busy, done, done_gid, err, err_idx} !== '0) begin
            fails++; $display("FAIL reset_outputs s=%h r=%h busy=%b done=%b gid=%0d err=%b eidx=%0d exp all 0",
                              s_out, r_out, busy, done, done_gid, err, err_idx);
        end
        tests++;
        if (req_if.req_ready !== 4'b0000) begin
            fails++; $display("FAIL idle_ready got=%b exp=0000", req_if.req_ready);
        end
    endtask

    task automatic test_single();
        set_req(0, 1'b1, 1'b1, 3'd5);
        #1;
        tests++;
        if (req_if.req_ready !== 4'b0001) begin
            fails++; $display("FAIL single_ready got=%b exp=0001", req_if.req_ready);
        end
        cyc(1);
        req_if.req_valid = '0;
        tests++;
        if ({s_out, r_out, busy} !== {8'h20, 8'h00, 1'b1}) begin
            fails++; $display("FAIL single_drive s=%h r=%h busy=%b exp s=20 r=00 busy=1", s_out, r_out, busy);
        end
        cyc(1);
        tests++;
        if ({s_out, r_out, done, flag_q[5]} !== {8'h00, 8'h00, 1'b0, 1'b1}) begin
            fails++; $display("FAIL single_verify s=%h r=%h done=%b q5=%b exp s=00 r=00 done=0 q5=1",
                              s_out, r_out, done, flag_q[5]);
        end
        cyc(1);
        tests++;
        if ({done, done_gid, err, busy} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL single_done done=%b gid=%0d err=%b busy=%b exp 1 0 0 0", done, done_gid, err, busy);
        end
        cyc(1);
        tests++;
        if (done !== 1'b0) begin
            fails++; $display("FAIL single_done_pulse done=%b exp=0", done);
        end
    endtask

    task automatic test_round_robin();
        int g_id [8];
        int g_c  [8];
        int n;
        int gid;
        n = 0;
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        req_if.req_valid = 4'b1111;
        req_if.req_op    = 4'b1111;
        req_if.req_idx   = {3'd4, 3'd3, 3'd2, 3'd1};
        for (int c = 0; c < 15; c++) begin
            #1;
            if (req_if.req_ready != 4'b0000 && n < 8) begin
                gid = 0;
                for (int k = 0; k < NR; k++) if (req_if.req_ready[k]) gid = k;
                g_id[n] = gid;
                g_c[n]  = c;
                n++;
            end
            if (c > 0 && c % 3 == 0) begin
                tests++;
                if ({done, done_gid} !== {1'b1, 2'((c/3 - 1) % 4)}) begin
                    fails++; $display("FAIL rr_done c=%0d done=%b gid=%0d exp done=1 gid=%0d", c, done, done_gid, (c/3 - 1) % 4);
                end
            end
            @(negedge clk);
        end
        req_if.req_valid = '0;
        tests++;
        if ({done, done_gid} !== {1'b1, 2'd0}) begin
            fails++; $display("FAIL rr_last_done done=%b gid=%0d exp done=1 gid=0", done, done_gid);
        end
        tests++;
        if (n != 5) begin
            fails++; $display("FAIL rr_grant_count got=%0d exp=5", n);
        end
        for (int i = 0; i < n && i < 5; i++) begin
            tests++;
            if (g_id[i] != i % 4 || g_c[i] != 3*i) begin
                fails++; $display("FAIL rr_grant%0d id=%0d cyc=%0d exp id=%0d cyc=%0d", i, g_id[i], g_c[i], i % 4, 3*i);
            end
        end
    endtask

    task automatic test_verify_fail();
        force_mask = 8'h04;
        force_val  = 8'h00;
        set_req(1, 1'b1, 1'b1, 3'd2);
        cyc(1);
        req_if.req_valid = '0;
        cyc(2);
        tests++;
        if ({err, err_idx, done, done_gid} !== {1'b1, 3'd2, 1'b1, 2'd1}) begin
            fails++; $display("FAIL vfail_first err=%b eidx=%0d done=%b gid=%0d exp 1 2 1 1", err, err_idx, done, done_gid);
        end
        force_mask = 8'h44;
        set_req(2, 1'b1, 1'b1, 3'd6);
        cyc(1);
        req_if.req_valid = '0;
        cyc(2);
        tests++;
        if ({err, err_idx} !== {1'b1, 3'd2}) begin
            fails++; $display("FAIL vfail_sticky err=%b eidx=%0d exp err=1 eidx=2", err, err_idx);
        end
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        tests++;
        if ({err, err_idx} !== {1'b0, 3'd0}) begin
            fails++; $display("FAIL err_clr err=%b eidx=%0d exp 0 0", err, err_idx);
        end
        set_req(3, 1'b1, 1'b1, 3'd6);
        cyc(1);
        req_if.req_valid = '0;
        cyc(1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        tests++;
        if ({err, done} !== {1'b0, 1'b1}) begin
            fails++; $display("FAIL err_clr_priority err=%b done=%b exp err=0 done=1", err, done);
        end
        force_mask = '0;
        set_req(0, 1'b1, 1'b0, 3'd5);
        cyc(1);
        req_if.req_valid = '0;
        tests++;
        if ({s_out, r_out} !== {8'h00, 8'h20}) begin
            fails++; $display("FAIL reset_op_drive s=%h r=%h exp s=00 r=20", s_out, r_out);
        end
        cyc(1);
        tests++;
        if (flag_q[5] !== 1'b0) begin
            fails++; $display("FAIL reset_op_flag q5=%b exp=0", flag_q[5]);
        end
        cyc(1);
        tests++;
        if ({err, done, done_gid} !== {1'b0, 1'b1, 2'd0}) begin
            fails++; $display("FAIL reset_op_done err=%b done=%b gid=%0d exp 0 1 0", err, done, done_gid);
        end
    endtask

    task automatic test_mid_reset();
        set_req(2, 1'b1, 1'b1, 3'd7);
        cyc(1);
        req_if.req_valid = '0;
        tests++;
        if (s_out !== 8'h80) begin
            fails++; $display("FAIL midrst_drive s=%h exp=80", s_out);
        end
        rst_n = 1'b0;
        cyc(1);
        tests++;
        if ({s_out, r_out, busy, done} !== '0) begin
            fails++; $display("FAIL midrst_clear s=%h r=%h busy=%b done=%b exp all 0", s_out, r_out, busy, done);
        end
        rst_n = 1'b1;
        cyc(1);
        tests++;
        if (done !== 1'b0) begin
            fails++; $display("FAIL midrst_no_done1 done=%b exp=0", done);
        end
        cyc(1);
        tests++;
        if (done !== 1'b0) begin
            fails++; $display("FAIL midrst_no_done2 done=%b exp=0", done);
        end
        req_if.req_valid = 4'b1111;
        #1;
        tests++;
        if (req_if.req_ready !== 4'b0001) begin
            fails++; $display("FAIL midrst_ptr ready=%b exp=0001", req_if.req_ready);
        end
        req_if.req_valid = '0;
        cyc(1);
    endtask

    task automatic test_random();
        logic [NF-1:0] ref_flags;
        logic [NF-1:0] prev_sr;
        logic [NR-1:0] v;
        logic [NR-1:0] exp_rdy;
        int mptr, next_idle, exp_done_c, exp_gid, win;
        int acc_cnt, done_cnt;
        int sr_viol, width_viol, rdy_viol, done_viol, model_viol;
        rst_n = 1'b0;
        req_if.req_valid = '0;
        cyc(1);
        rst_n = 1'b1;
        ref_flags = bank_q;
        prev_sr = '0;
        mptr = 0; next_idle = 0; exp_done_c = -1; exp_gid = 0;
        acc_cnt = 0; done_cnt = 0;
        sr_viol = 0; width_viol = 0; rdy_viol = 0; done_viol = 0; model_viol = 0;
        for (int c = 0; c < 10000; c++) begin
            if ((s_out & r_out) != '0 || $countones(s_out | r_out) > 1) sr_viol++;
            if ((s_out | r_out) != '0 && prev_sr != '0) width_viol++;
            prev_sr = s_out | r_out;
            if (done === 1'b1) done_cnt++;
            if (done !== (c == exp_done_c)) done_viol++;
            if (c == exp_done_c) begin
                if (done_gid !== 2'(exp_gid)) done_viol++;
                if (bank_q !== ref_flags) model_viol++;
            end
            v = (c < 9990) ? 4'($urandom_range(0, 15)) : 4'b0000;
            req_if.req_valid = v;
            req_if.req_op    = 4'($urandom);
            req_if.req_idx   = 12'($urandom);
            #1;
            exp_rdy = '0;
            win = -1;
            if (c >= next_idle)
                for (int off = 0; off < NR; off++)
                    if (win < 0 && v[(mptr + off) % NR]) win = (mptr + off) % NR;
            if (win >= 0) exp_rdy[win] = 1'b1;
            if (req_if.req_ready !== exp_rdy) rdy_viol++;
            if (win >= 0) begin
                ref_flags[req_if.req_idx[win*IW +: IW]] = req_if.req_op[win];
                exp_gid    = win;
                exp_done_c = c + 3;
                next_idle  = c + 3;
                mptr       = (win + 1) % NR;
                acc_cnt++;
            end
            @(negedge clk);
        end
        tests++;
        if (sr_viol != 0) begin fails++; $display("FAIL rand_sr_overlap count=%0d exp=0", sr_viol); end
        tests++;
        if (width_viol != 0) begin fails++; $display("FAIL rand_pulse_width count=%0d exp=0", width_viol); end
        tests++;
        if (rdy_viol != 0) begin fails++; $display("FAIL rand_ready_arb count=%0d exp=0", rdy_viol); end
        tests++;
        if (done_viol != 0) begin fails++; $display("FAIL rand_done_timing count=%0d exp=0", done_viol); end
        tests++;
        if (model_viol != 0 || bank_q !== ref_flags) begin
            fails++; $display("FAIL rand_flag_model count=%0d bank=%h exp=%h", model_viol, bank_q, ref_flags);
        end
        tests++;
        if (done_cnt != acc_cnt || acc_cnt < 100) begin
            fails++; $display("FAIL rand_done_count done=%0d accepts=%0d", done_cnt, acc_cnt);
        end
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL rand_err err=%b exp=0", err); end
    endtask

    initial begin
        req_if.req_valid = '0;
        req_if.req_op    = '0;
        req_if.req_idx   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_verify_fail();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog timeout reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
